// File: rtl/unlock_seq_arbiter_pkg.sv
// unlock_pkg: shared bytes, status codes and controller states for the unlock sequence arbiter
package unlock_pkg;

    localparam logic [7:0] SEQ_B0 = 8'h81;
    localparam logic [7:0] SEQ_B1 = 8'h42;
    localparam logic [7:0] SEQ_B2 = 8'h24;
    localparam logic [7:0] SEQ_B3 = 8'h18;
    localparam logic [7:0] HOLD_B = 8'h1C;
    localparam logic [7:0] IDLE_B = 8'h00;

    localparam logic [7:0] ST_INIT = 8'h01;
    localparam logic [7:0] ST_S1   = 8'h03;
    localparam logic [7:0] ST_S2   = 8'h05;
    localparam logic [7:0] ST_S3   = 8'h09;
    localparam logic [7:0] ST_OPEN = 8'h11;

    typedef enum logic [2:0] {IDLE, SEND, HOLD, FLUSH, DONE} state_t;

    // Byte driven at a given position of the 4-byte unlock sequence
    function automatic logic [7:0] seq_byte(input logic [1:0] i);
        return i == 2'd0 ? SEQ_B0 : i == 2'd1 ? SEQ_B1 : i == 2'd2 ? SEQ_B2 : SEQ_B3;
    endfunction

    // Status code the detector must report after consuming byte b
    function automatic logic [7:0] exp_code(input logic [7:0] b);
        return b == SEQ_B0 ? ST_S1 :
               b == SEQ_B1 ? ST_S2 :
               b == SEQ_B2 ? ST_S3 :
               (b == SEQ_B3 || b == HOLD_B) ? ST_OPEN : ST_INIT;
    endfunction

endpackage

// File: rtl/unlock_seq_arbiter_rr_arbiter.sv
// rr_arbiter: picks the lowest requesting index at or after the round-robin pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PW-1:0]      win_idx,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [PW-1:0]        off;
    logic [PW:0]          sum;

    assign dbl = {req, req} >> ptr;

    // Distance from the pointer to the first active request (rotated view)
    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (dbl[k]) off = PW'(k);
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign win_idx = PW'(sum >= (PW+1)'(NUM_REQ) ? sum - (PW+1)'(NUM_REQ) : sum);
    assign any_req = |req;
    assign win     = NUM_REQ'(any_req) << win_idx;

endmodule

// File: rtl/unlock_seq_arbiter.sv
// unlock_seq_arbiter: round-robin shares the unlock detector, drives its sequence and checks its status codes
module unlock_seq_arbiter
    import unlock_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         det_in_val,
    input  logic [7:0]         det_out_val
);

    localparam int PW = $clog2(NUM_REQ);

    state_t             state, state_n;
    logic [1:0]         idx, idx_n;
    logic [7:0]         cnt, cnt_n, din_n;
    logic [7:0]         exp1, exp2;
    logic [PW-1:0]      ptr, gidx, win_idx;
    logic [NUM_REQ-1:0] win;
    logic               any_req, grant, chk, mism, fail;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    // Next state, step/hold counters and the byte to present next cycle
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        case (state)
            IDLE:  if (any_req) begin state_n = SEND; idx_n = 2'd0; end
            SEND: begin
                idx_n = idx + 2'd1;
                if (idx == 2'd3) begin state_n = HOLD; cnt_n = 8'(HOLD_CYCLES); end
            end
            HOLD: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin state_n = FLUSH; idx_n = 2'd0; end
            end
            FLUSH: begin
                idx_n = idx + 2'd1;
                if (idx == 2'd1) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        din_n = state_n == SEND ? seq_byte(idx_n) : state_n == HOLD ? HOLD_B : IDLE_B;
    end

    assign grant = state == IDLE && any_req;
    assign chk   = (state == SEND && idx[1]) || state == HOLD || state == FLUSH || state == DONE;
    assign mism  = chk && det_out_val != exp2;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign pass  = done && !fail && !mism;

    // Controller state and the registered detector input byte
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= 8'd0;
            det_in_val <= IDLE_B;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            det_in_val <= din_n;
        end
    end

    // Grant, round-robin pointer, expected-code pipeline and sticky fail flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt  <= '0;
            gidx <= '0;
            ptr  <= '0;
            fail <= 1'b0;
            exp1 <= ST_INIT;
            exp2 <= ST_INIT;
        end else begin
            gnt  <= state_n == IDLE ? '0 : grant ? win : gnt;
            gidx <= grant ? win_idx : gidx;
            ptr  <= !done ? ptr : gidx == PW'(NUM_REQ - 1) ? '0 : gidx + PW'(1);
            fail <= grant ? 1'b0 : fail | mism;
            exp1 <= exp_code(det_in_val);
            exp2 <= exp1;
        end
    end

endmodule

// File: tb/tb_unlock_seq_arbiter.sv
// tb_unlock_seq_arbiter: directed stimulus with a service-level model and a behavioural unlock detector
module tb_unlock_seq_arbiter;

    localparam int N = 2;
    localparam int H = 4;
    localparam int L = H + 7;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         busy, done, pass;
    logic [7:0]   din, dout;
    logic         force_en = 1'b0;
    logic [7:0]   force_val = 8'h00;
    logic [1:0]   areq = '0;
    logic [1:0]   agnt [2];
    logic         abusy [2], adone [2], apass [2];
    logic [7:0]   adin [2], adout [2];
    logic [7:0]   dins [3];
    int           ds [3] = '{0, 0, 0};
    logic [7:0]   dq [3] = '{8'h00, 8'h00, 8'h00};
    int           checks = 0, errors = 0;
    logic         started = 1'b0;
    int           m_busy = 0, m_pos = 0, m_g = 0, m_ptr = 0, m_bad = 0;

    always #5 clk = ~clk;

    unlock_seq_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .busy(busy), .done(done),
        .pass(pass), .det_in_val(din), .det_out_val(dout)
    );

    unlock_seq_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rstn(rstn), .req({1'b0, areq[0]}), .gnt(agnt[0]), .busy(abusy[0]),
        .done(adone[0]), .pass(apass[0]), .det_in_val(adin[0]), .det_out_val(adout[0])
    );

    unlock_seq_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(255)) u_h255 (
        .clk(clk), .rstn(rstn), .req({1'b0, areq[1]}), .gnt(agnt[1]), .busy(abusy[1]),
        .done(adone[1]), .pass(apass[1]), .det_in_val(adin[1]), .det_out_val(adout[1])
    );

    function automatic logic [7:0] st_code(input int s);
        case (s)
            1: return 8'h03;
            2: return 8'h05;
            3: return 8'h09;
            4: return 8'h11;
            default: return 8'h01;
        endcase
    endfunction

    function automatic int det_next(input int s, input logic [7:0] b);
        if (b == 8'h81) return 1;
        if (s == 1 && b == 8'h42) return 2;
        if (s == 2 && b == 8'h24) return 3;
        if (s == 3 && b == 8'h18) return 4;
        if (s == 4 && b == 8'h1C) return 4;
        return 0;
    endfunction

    function automatic logic [7:0] seq_at(input int p);
        case (p)
            1: return 8'h81;
            2: return 8'h42;
            3: return 8'h24;
            4: return 8'h18;
            default: return (p >= 5 && p <= 4 + H) ? 8'h1C : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] code_of(input logic [7:0] b);
        case (b)
            8'h81: return 8'h03;
            8'h42: return 8'h05;
            8'h24: return 8'h09;
            8'h18, 8'h1C: return 8'h11;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] exp_at(input int p);
        return code_of(seq_at(p - 2));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    assign dins[0] = din;
    assign dins[1] = adin[0];
    assign dins[2] = adin[1];
    assign dout     = force_en ? force_val : st_code(ds[0]);
    assign adout[0] = st_code(ds[1]);
    assign adout[1] = st_code(ds[2]);

    // Unlock detector: registered input stage followed by the pattern state register
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            ds[k] <= !rstn ? 0 : det_next(ds[k], dq[k]);
            dq[k] <= !rstn ? 8'h00 : dins[k];
        end
    end

    // Service-level model: who is granted, how far into the service, and whether any checked code was wrong
    always @(posedge clk) begin
        if (!rstn) begin
            m_busy = 0; m_pos = 0; m_g = 0; m_ptr = 0; m_bad = 0;
        end else if (m_busy != 0) begin
            if (m_pos >= 3 && dout !== exp_at(m_pos)) m_bad = 1;
            if (m_pos == L) begin
                m_busy = 0;
                m_ptr = (m_g + 1) % N;
            end else m_pos++;
        end else if (req != '0) begin
            for (int k = N - 1; k >= 0; k--)
                if (((int'(req) >> ((m_ptr + k) % N)) & 1) != 0) m_g = (m_ptr + k) % N;
            m_busy = 1; m_pos = 1; m_bad = 0;
        end
    end

    // Compare main DUT against the model every cycle
    always @(negedge clk) begin
        if (started) begin
            chk("gnt", 32'(gnt), m_busy != 0 ? 32'(1 << m_g) : 32'd0);
            chk("busy", 32'(busy), 32'(m_busy != 0));
            chk("det_in_val", 32'(din), m_busy != 0 ? 32'(seq_at(m_pos)) : 32'd0);
            chk("done", 32'(done), 32'(m_busy != 0 && m_pos == L));
            if (m_busy != 0 && m_pos == L)
                chk("pass", 32'(pass), 32'(!(m_bad != 0 || dout !== exp_at(L))));
        end
    end

    task automatic run_aux(input int k, input int exp_len, input int exp_1c);
        int n, c;
        logic got, p;
        n = 0; c = 0; got = 1'b0; p = 1'b0;
        areq[k] = 1'b1;
        tick(1);
        areq[k] = 1'b0;
        chk($sformatf("aux%0d_gnt", k), 32'(agnt[k]), 32'd1);
        for (int i = 0; i < 400 && !got; i++) begin
            n++;
            if (adin[k] == 8'h1C) c++;
            if (adone[k]) begin
                got = 1'b1;
                p = apass[k];
            end else tick(1);
        end
        chk($sformatf("aux%0d_done_seen", k), 32'(got), 32'd1);
        chk($sformatf("aux%0d_len", k), 32'(n), 32'(exp_len));
        chk($sformatf("aux%0d_hold_bytes", k), 32'(c), 32'(exp_1c));
        chk($sformatf("aux%0d_pass", k), 32'(p), 32'd1);
        tick(2);
    endtask

    initial begin
        rstn = 1'b0;
        tick(1);
        started = 1'b1;
        tick(2);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        rstn = 1'b1;
        tick(2);
        // single requester, full service
        req = 2'b01;
        tick(1);
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_b0", 32'(din), 32'h81);
        req = 2'b00;
        tick(4);
        chk("t1_hold", 32'(din), 32'h1C);
        tick(4);
        chk("t1_flush", 32'(din), 32'h00);
        tick(2);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_gnt_done", 32'(gnt), 32'd1);
        tick(1);
        chk("t1_idle", 32'(busy), 32'd0);
        // wrong status code in first HOLD cycle, then a clean service
        req = 2'b01;
        tick(1);
        req = 2'b00;
        tick(4);
        force_en = 1'b1;
        force_val = 8'h05;
        tick(1);
        force_en = 1'b0;
        tick(5);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        tick(1);
        req = 2'b01;
        tick(1);
        req = 2'b00;
        tick(10);
        chk("t2b_done", 32'(done), 32'd1);
        chk("t2b_pass", 32'(pass), 32'd1);
        tick(1);
        // serve requester 1 so the pointer returns to 0
        req = 2'b10;
        tick(1);
        chk("pre3_gnt", 32'(gnt), 32'd2);
        req = 2'b00;
        tick(11);
        // simultaneous requests with pointer 0
        req = 2'b11;
        tick(1);
        chk("t3_gnt0", 32'(gnt), 32'd1);
        tick(10);
        chk("t3_done0", 32'(done), 32'd1);
        chk("t3_done0_gnt", 32'(gnt), 32'd1);
        tick(1);
        chk("t3_gap_busy", 32'(busy), 32'd0);
        chk("t3_gap_gnt", 32'(gnt), 32'd0);
        tick(1);
        chk("t3_gnt1", 32'(gnt), 32'd2);
        req = 2'b00;
        tick(10);
        chk("t3_done1", 32'(done), 32'd1);
        tick(1);
        // pointer back at 0; request dropped during SEND idx1
        req = 2'b11;
        tick(1);
        chk("t4_gnt", 32'(gnt), 32'd1);
        tick(1);
        req = 2'b00;
        chk("t4_b1", 32'(din), 32'h42);
        tick(9);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_gnt_done", 32'(gnt), 32'd1);
        chk("t4_pass", 32'(pass), 32'd1);
        tick(1);
        // reset during HOLD cycle 2
        req = 2'b01;
        tick(1);
        req = 2'b00;
        tick(5);
        chk("t5_in_hold", 32'(din), 32'h1C);
        rstn = 1'b0;
        tick(1);
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_din", 32'(din), 32'd0);
        rstn = 1'b1;
        tick(1);
        req = 2'b01;
        tick(1);
        req = 2'b00;
        tick(10);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_pass", 32'(pass), 32'd1);
        tick(2);
        // hold length extremes
        run_aux(0, 8, 1);
        run_aux(1, 262, 255);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
